// File: rtl/logic_unit_pkg.sv
// Shared definitions for the LogicUnit and its round-robin arbiter.
// Contents: fixed LogicUnit widths, opcode encodings, sequencer state
// encoding and the opcode legality check.
package logic_unit_pkg;

    localparam int unsigned LU_DATA_W = 32;
    localparam int unsigned LU_OP_W   = 6;

    localparam logic [LU_OP_W-1:0] OP_NOT  = 6'd1;
    localparam logic [LU_OP_W-1:0] OP_OR   = 6'd2;
    localparam logic [LU_OP_W-1:0] OP_AND  = 6'd3;
    localparam logic [LU_OP_W-1:0] OP_NOR  = 6'd4;
    localparam logic [LU_OP_W-1:0] OP_NAND = 6'd5;
    localparam logic [LU_OP_W-1:0] OP_XOR  = 6'd6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [LU_OP_W-1:0] op);
        return (op >= OP_NOT) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/logic_unit.sv
// Combinational 32-bit logic unit.
// Ports:
//   a, b  in  operands
//   sel   in  opcode (NOT A, OR, AND, NOR, NAND, XOR); illegal opcodes give 0
//   y     out result
module logic_unit
    import logic_unit_pkg::*;
(
    input  logic [LU_DATA_W-1:0] a,
    input  logic [LU_DATA_W-1:0] b,
    input  logic [LU_OP_W-1:0]   sel,
    output logic [LU_DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            OP_NOT:  y = ~a;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_NOR:  y = ~(a | b);
            OP_NAND: y = ~(a & b);
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one logic_unit between NUM_REQ requesters.
// One request is accepted at a time; its operands are latched, executed, and the
// result is returned with the owning requester id.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b/req_op   packed per-requester operands/opcode, requester i at [i*W +: W]
//   resp_valid/ready     result handshake
//   resp_data/id/err     result, owning requester, illegal-opcode flag
//   busy                 sequencer not idle
//   ops_done             saturating count of completed response handshakes
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_err,
    output logic                      busy,
    output logic [CNT_W-1:0]          ops_done
);

    state_e              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [OP_W-1:0]     op_sel;
    logic [ID_W-1:0]     op_id;
    logic [DATA_W-1:0]   lu_y;

    // First asserted valid found scanning from ptr upwards, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        grant     = rr_pick(req_valid, rr_ptr);
        req_ready = '0;
        // rst_n gate keeps req_ready low while reset is held with valids asserted
        if ((state == StIdle) && rst_n && (|req_valid)) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign busy = (state != StIdle);

    logic_unit u_lu (
        .a   (op_a),
        .b   (op_b),
        .sel (op_sel),
        .y   (lu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
            ops_done   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req_valid) begin
                        op_a   <= req_a[grant*DATA_W +: DATA_W];
                        op_b   <= req_b[grant*DATA_W +: DATA_W];
                        op_sel <= req_op[grant*OP_W +: OP_W];
                        op_id  <= grant;
                        if (grant == ID_W'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant + 1'b1;
                        end
                        state <= StExec;
                    end
                end
                StExec: begin
                    // logic_unit already returns 0 for illegal opcodes
                    resp_data  <= lu_y;
                    resp_err   <= ~is_legal_op(op_sel);
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (ops_done != '1) begin
                            ops_done <= ops_done + 1'b1;
                        end
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 6;
    localparam int IW = 2;
    localparam int CW = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*OW-1:0] req_op;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_data;
    logic [IW-1:0]   resp_id;
    logic            resp_err;
    logic            busy;
    logic [CW-1:0]   ops_done;

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;
    int ops_m    = 0;

    logic_unit_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .OP_W    (OW),
        .ID_W    (IW),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int rr_model(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] lu_model(input logic [OW-1:0] op,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            6'd1:    return ~a;
            6'd2:    return a | b;
            6'd3:    return a & b;
            6'd4:    return ~(a | b);
            6'd5:    return ~(a & b);
            6'd6:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] op);
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
        req_op[i*OW +: OW] = op;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            set_req(i, $urandom, $urandom, OW'($urandom));
        end
    endtask

    // Caller is positioned #1 after a rising edge with the sequencer idle.
    task automatic run_op(input logic [N-1:0] mask, input int stall, output int g,
                          output logic [DW-1:0] got);
        logic [DW-1:0] ea, eb, ed;
        logic [OW-1:0] eop;
        logic          eerr;
        logic [IW-1:0] gid;
        logic [63:0]   snap;
        req_valid = mask;
        got = '0;
        #1;
        if (mask == '0) begin
            g = -1;
            check("idle_ready", 64'(req_ready), 64'(0));
            @(posedge clk); #1;
            check("idle_busy", 64'(busy), 64'(0));
            return;
        end
        g = rr_model(mask);
        check("grant", 64'(req_ready), 64'(1) << g);
        ea  = req_a[g*DW +: DW];
        eb  = req_b[g*DW +: DW];
        eop = req_op[g*OW +: OW];
        @(posedge clk); #1;
        ptr_m = (g + 1) % N;
        // requester inputs change after acceptance; result must use latched values
        req_valid = N'($urandom);
        scramble();
        check("exec", {busy, resp_valid, req_ready}, {1'b1, 1'b0, 4'b0});
        @(posedge clk); #1;
        ed   = lu_model(eop, ea, eb);
        eerr = !(eop >= 6'd1 && eop <= 6'd6);
        gid  = g[IW-1:0];
        snap = {resp_valid, resp_data, resp_id, resp_err};
        got  = resp_data;
        check("resp", snap, {1'b1, ed, gid, eerr});
        for (int s = 0; s < stall; s++) begin
            resp_ready = 1'b0;
            req_valid  = N'($urandom);
            @(posedge clk); #1;
            check("hold", {resp_valid, resp_data, resp_id, resp_err, req_ready},
                  {1'b1, ed, gid, eerr, 4'b0});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = '0;
        if (ops_m < 15) ops_m++;
        check("done", {resp_valid, busy, ops_done}, {1'b0, 1'b0, CW'(ops_m)});
    endtask

    initial begin
        int g;
        logic [DW-1:0] r;
        logic [N-1:0] m;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check("rst_state", {busy, resp_valid, resp_data, resp_id, resp_err, ops_done, req_ready},
              64'(0));
        req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single XOR request from requester 0
        set_req(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd6);
        run_op(4'b0001, 0, g, r);
        check("xor_value", 64'(r), 64'h0000_0000_FF00_FF00);

        // all requesters valid: grants rotate 1,2,3,0,1 since ptr sits at 1
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 32'h0, $urandom, 6'd1);
            run_op(4'b1111, 0, g, r);
            check("rr_order", 64'(g), 64'((k + 1) % N));
            check("not_zero", 64'(r), 64'hFFFF_FFFF);
        end

        // backpressure for 10 cycles
        scramble();
        run_op(4'b0110, 10, g, r);

        // reset while in EXEC
        scramble();
        req_valid = 4'b1000;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid", {busy, resp_valid, ops_done, req_ready}, 64'(0));
        ptr_m = 0;
        ops_m = 0;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("no_resp", {busy, resp_valid}, 64'(0));

        // illegal opcodes
        set_req(0, $urandom, $urandom, 6'd0);
        run_op(4'b0001, 1, g, r);
        set_req(1, $urandom, $urandom, 6'd63);
        run_op(4'b0010, 0, g, r);

        // requester 2 latched-operand case
        set_req(2, 32'h1234_5678, 32'hFFFF_0000, 6'd3);
        run_op(4'b0100, 0, g, r);
        check("latched_a", 64'(r), 64'h0000_0000_1234_0000);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            scramble();
            if ($urandom_range(0, 7) == 0) set_req($urandom_range(0, N - 1), $urandom, $urandom,
                                                  6'd63);
            m = N'($urandom);
            run_op(m, $urandom_range(0, 3), g, r);
        end
        // at least 17 handshakes since reset: counter stuck at all-ones
        for (int t = 0; t < 14; t++) begin
            scramble();
            run_op(4'b1111, 0, g, r);
        end
        check("sat", 64'(ops_done), 64'(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
